// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: MMIO register offsets,
// STATUS bit positions and the responder's top-level state type.
package cpu_mem_pkg;

  localparam logic [15:0] SEG1_OFS   = 16'd0;
  localparam logic [15:0] SEG2_OFS   = 16'd1;
  localparam logic [15:0] CYC_LO_OFS = 16'd2;
  localparam logic [15:0] CYC_HI_OFS = 16'd3;
  localparam logic [15:0] STATUS_OFS = 16'd4;
  localparam logic [15:0] HWM_OFS    = 16'd5;

  localparam int STATUS_FAULT_BIT = 0;
  localparam int STATUS_READY_BIT = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with registered read; a read that coincides with
// a write to the same word returns the word's previous contents.
module ram_sp_sync #(
  parameter  int DEPTH  = 1024,
  parameter  int DATA_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Data-memory bus responder: zero-fills the stack RAM after reset, then serves
// RAM accesses and a small MMIO window (seven-segment, cycle counter, status, HWM).
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address_ram,
  input  logic [15:0] data_ram,
  input  logic        wren_ram,
  output logic [15:0] q_ram,
  output logic [15:0] SEG1,
  output logic [15:0] SEG2,
  output logic        ready,
  output logic        fault
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [16:0]    DEPTH_L  = 17'(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  mem_state_t    r_state;
  mem_state_t    w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [31:0]   r_cycle;
  logic [15:0]   r_shadow;
  logic [15:0]   r_hwm;
  logic [15:0]   r_mmio_q;
  logic          r_sel_ram;

  logic          w_run;
  logic          w_is_ram;
  logic          w_is_mmio;
  logic [15:0]   w_ofs;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [15:0]   w_ram_d;
  logic [15:0]   w_ram_q;
  logic [15:0]   w_mmio_rd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= CLEAR;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_idx == LAST_IDX) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign w_run     = (r_state == RUN);
  assign ready     = w_run;
  assign w_ofs     = address_ram - MMIO_BASE;
  assign w_is_ram  = ({1'b0, address_ram} < DEPTH_L);
  assign w_is_mmio = (address_ram >= MMIO_BASE) && (w_ofs <= HWM_OFS);

  // The clear counter owns the RAM port until the fill completes.
  assign w_ram_we   = w_run ? (wren_ram & w_is_ram) : 1'b1;
  assign w_ram_addr = w_run ? address_ram[AW-1:0] : r_clr_idx;
  assign w_ram_d    = w_run ? data_ram : 16'h0000;

  ram_sp_sync #(
    .DEPTH  (DEPTH),
    .DATA_W (16)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_d),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    w_mmio_rd = 16'h0000;
    if (w_is_mmio) begin
      case (w_ofs)
        SEG1_OFS:   w_mmio_rd = SEG1;
        SEG2_OFS:   w_mmio_rd = SEG2;
        CYC_LO_OFS: w_mmio_rd = r_cycle[15:0];
        CYC_HI_OFS: w_mmio_rd = r_shadow;
        STATUS_OFS: begin
          w_mmio_rd[STATUS_FAULT_BIT] = fault;
          w_mmio_rd[STATUS_READY_BIT] = ready;
        end
        HWM_OFS:    w_mmio_rd = r_hwm;
        default:    w_mmio_rd = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_idx <= '0;
      r_cycle   <= 32'd0;
      r_shadow  <= 16'h0000;
      r_hwm     <= 16'h0000;
      r_mmio_q  <= 16'h0000;
      r_sel_ram <= 1'b0;
      SEG1      <= 16'h0000;
      SEG2      <= 16'h0000;
      fault     <= 1'b0;
    end else if (!w_run) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      r_mmio_q  <= 16'h0000;
      r_sel_ram <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      r_sel_ram <= w_is_ram;
      r_mmio_q  <= w_mmio_rd;
      if (!w_is_ram && !w_is_mmio) fault <= 1'b1;
      if (wren_ram) begin
        if (w_is_ram && (address_ram > r_hwm)) r_hwm <= address_ram;
        if (w_is_mmio) begin
          case (w_ofs)
            SEG1_OFS:   SEG1 <= data_ram;
            SEG2_OFS:   SEG2 <= data_ram;
            STATUS_OFS: if (data_ram[STATUS_FAULT_BIT]) fault <= 1'b0;
            default:    ;
          endcase
        end
      end else if (w_is_mmio && (w_ofs == CYC_LO_OFS)) begin
        r_shadow <= r_cycle[31:16];
      end
    end
  end

  // Illegal accesses and clear cycles leave r_sel_ram low with r_mmio_q zero.
  assign q_ram = r_sel_ram ? w_ram_q : r_mmio_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed bus scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the memory map.
module tb_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'hFF00;

  logic        clock;
  logic        reset_n;
  logic [15:0] address_ram;
  logic [15:0] data_ram;
  logic        wren_ram;
  logic [15:0] q_ram;
  logic [15:0] SEG1;
  logic [15:0] SEG2;
  logic        ready;
  logic        fault;

  mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address_ram (address_ram),
    .data_ram    (data_ram),
    .wren_ram    (wren_ram),
    .q_ram       (q_ram),
    .SEG1        (SEG1),
    .SEG2        (SEG2),
    .ready       (ready),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_seg1, m_seg2, m_shadow, m_hwm, m_q;
  logic [31:0] m_cyc;
  logic        m_fault;
  int          m_clear_left;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    m_seg1 = 0; m_seg2 = 0; m_shadow = 0; m_hwm = 0; m_q = 0;
    m_cyc = 0; m_fault = 0; m_clear_left = DEPTH;
  endtask

  task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic w);
    int ai;
    ai = int'(a);
    m_q = 16'h0000;
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      if (ai < DEPTH) begin
        m_q = m_mem[ai];
        if (w) begin
          m_mem[ai] = d;
          if (a > m_hwm) m_hwm = a;
        end
      end else if (ai >= int'(BASE) && ai <= int'(BASE) + 5) begin
        case (ai - int'(BASE))
          0: begin m_q = m_seg1; if (w) m_seg1 = d; end
          1: begin m_q = m_seg2; if (w) m_seg2 = d; end
          2: begin m_q = m_cyc[15:0]; if (!w) m_shadow = m_cyc[31:16]; end
          3: m_q = m_shadow;
          4: begin m_q = {14'd0, 1'b1, m_fault}; if (w && d[0]) m_fault = 1'b0; end
          default: m_q = m_hwm;
        endcase
      end else begin
        m_fault = 1'b1;
      end
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_q"},     q_ram, m_q);
    chk({pfx, "_seg1"},  SEG1,  m_seg1);
    chk({pfx, "_seg2"},  SEG2,  m_seg2);
    chk({pfx, "_ready"}, {15'd0, ready}, {15'd0, (m_clear_left == 0)});
    chk({pfx, "_fault"}, {15'd0, fault}, {15'd0, m_fault});
  endtask

  // Drive one access, let one edge sample it, then compare everything 1 ns later.
  task automatic step(input string pfx, input logic [15:0] a, input logic [15:0] d, input logic w);
    address_ram = a; data_ram = d; wren_ram = w;
    model_step(a, d, w);
    @(posedge clock);
    #1;
    check_outputs(pfx);
  endtask

  task automatic do_reset(input string pfx);
    reset_n = 1'b0;
    model_reset();
    #2;
    check_outputs(pfx);
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom % 5)
      0, 1:    return 16'($urandom % DEPTH);
      2:       return BASE + 16'($urandom % 6);
      3:       return BASE + 16'd6 + 16'($urandom % 10);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; address_ram = 0; data_ram = 0; wren_ram = 0;
    model_reset();
    @(posedge clock); #1;
    do_reset("rst");

    // Clear phase: accesses ignored, ready rises after DEPTH edges
    for (int i = 0; i < DEPTH; i++) step("clear", 16'd5, 16'hFFFF, 1'b1);
    step("rd5", 16'd5, 16'd0, 1'b0);

    step("wr3", 16'd3, 16'h1234, 1'b1);
    step("rd3", 16'd3, 16'd0, 1'b0);
    step("hwm_a", BASE + 16'd5, 16'd0, 1'b0);
    step("wr1", 16'd1, 16'h5555, 1'b1);
    step("hwm_b", BASE + 16'd5, 16'd0, 1'b0);
    step("wr0", 16'd0, 16'h7777, 1'b1);
    step("rdw3", 16'd3, 16'hAAAA, 1'b1);
    step("rd3b", 16'd3, 16'd0, 1'b0);

    step("seg1w", BASE, 16'hBEEF, 1'b1);
    step("seg2w", BASE + 16'd1, 16'h00AA, 1'b1);
    step("seg1r", BASE, 16'd0, 1'b0);
    step("seg2r", BASE + 16'd1, 16'd0, 1'b0);

    step("ill400", 16'h0400, 16'd0, 1'b0);
    step("illdep", 16'(DEPTH), 16'd0, 1'b0);
    step("stat_r", BASE + 16'd4, 16'd0, 1'b0);
    step("fclr", BASE + 16'd4, 16'h0001, 1'b1);
    step("ro_wr", BASE + 16'd5, 16'h00FF, 1'b1);
    step("cyc_wr", BASE + 16'd2, 16'h1111, 1'b1);
    step("ill9w", BASE + 16'd9, 16'h1111, 1'b1);
    step("ill9r", BASE + 16'd9, 16'd0, 1'b0);
    step("fclr2", BASE + 16'd4, 16'h0001, 1'b1);
    step("illnx", 16'hFF0F, 16'd0, 1'b0);
    step("fnop", BASE + 16'd4, 16'h0002, 1'b1);

    // Cycle counter: shadowed upper half, then wrap
    force dut.r_cycle = 32'h0001FFFF;
    #1;
    release dut.r_cycle;
    m_cyc = 32'h0001FFFF;
    step("cyclo", BASE + 16'd2, 16'd0, 1'b0);
    step("cychi", BASE + 16'd3, 16'd0, 1'b0);
    force dut.r_cycle = 32'hFFFFFFFE;
    #1;
    release dut.r_cycle;
    m_cyc = 32'hFFFFFFFE;
    step("wrap0", BASE + 16'd2, 16'd0, 1'b0);
    step("wrap1", BASE + 16'd2, 16'd0, 1'b0);
    step("wrap2", BASE + 16'd3, 16'd0, 1'b0);
    step("wrap3", BASE + 16'd2, 16'd0, 1'b0);
    step("wrap4", BASE + 16'd3, 16'd0, 1'b0);

    for (int i = 0; i < 400; i++)
      step("rnd", rand_addr(), 16'($urandom), 1'($urandom % 2));

    // Reset mid-run: outputs drop at once, full clear runs again
    step("preseg", BASE, 16'hC0DE, 1'b1);
    do_reset("rst_run");
    for (int i = 0; i < DEPTH; i++) step("clear2", rand_addr(), 16'($urandom), 1'b1);
    for (int i = 0; i < DEPTH; i++) step("zero", 16'(i), 16'd0, 1'b0);

    // Reset mid-clear: clear restarts from index 0 and takes DEPTH cycles again
    for (int i = 0; i < 20; i++) step("rnd2", rand_addr(), 16'($urandom), 1'($urandom % 2));
    do_reset("rst_pre");
    for (int i = 0; i < 5; i++) step("clear3", 16'd2, 16'h1, 1'b1);
    do_reset("rst_clr");
    for (int i = 0; i < DEPTH; i++) step("clear4", 16'd2, 16'h1, 1'b1);
    for (int i = 0; i < 200; i++)
      step("rnd3", rand_addr(), 16'($urandom), 1'($urandom % 2));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
